mux_4to1_rr_arbiter: RTL and testbench

//   Round-robin arbiter/sequencer that shares a 4:1 gate-level mux (inputs
//   a,b,c,d; 2-bit sel) between four requesters. Grants one requester at a

---
 rtl/mux_4to1_rr_arbiter.sv | 124 ++++++++++++
 tb/tb_mux_4to1_rr_arbiter.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mux_4to1_rr_arbiter.sv
// Round-robin arbiter driving the select of a shared 4:1 mux, with burst limit.
// Optional MUX_ARB_LOCK_EN adds a lock input that suspends the burst limit.
module mux_4to1_rr_arbiter #(
  parameter int MAX_BURST = 4,
  parameter int CNT_W     = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] req,
  input  logic       out_ready,
`ifdef MUX_ARB_LOCK_EN
  input  logic       lock,
`endif
  output logic [3:0] gnt,
  output logic [1:0] sel,
  output logic       out_valid,
  output logic       busy
);

  typedef enum logic {IDLE, GRANT} state_e;

  localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_BURST - 1);

  state_e           state_q, state_d;
  logic [3:0]       gnt_q, gnt_d;
  logic [1:0]       sel_q, sel_d;
  logic [1:0]       last_q, last_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             busy_q, busy_d;
  logic             lock_w;
  logic             own_req;
  logic             xfer;
  logic             rel;
  logic [1:0]       win;

`ifdef MUX_ARB_LOCK_EN
  assign lock_w = lock;
`else
  assign lock_w = 1'b0;
`endif

  // First set bit of r, scanning upward from index 'from' with wrap.
  function automatic logic [1:0] rr_pick(
    input logic [3:0] r,
    input logic [1:0] from
  );
    logic [1:0] idx;
    rr_pick = from;
    for (int k = 3; k >= 0; k--) begin
      idx = from + 2'(k);
      if (r[idx]) rr_pick = idx;
    end
  endfunction

  assign own_req   = req[sel_q];
  assign out_valid = |(gnt_q & req);
  assign xfer      = out_valid & out_ready;
  assign rel       = ~own_req
                   | (xfer & ~lock_w & (cnt_q >= LIMIT));

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    sel_d   = sel_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    win     = 2'd0;
    unique case (state_q)
      IDLE: begin
        if (|req) begin
          win     = rr_pick(req, last_q + 2'd1);
          state_d = GRANT;
          gnt_d   = 4'b0001 << win;
          sel_d   = win;
          busy_d  = 1'b1;
          cnt_d   = '0;
        end
      end
      GRANT: begin
        if (rel) begin
          last_d = sel_q;
          cnt_d  = '0;
          if (|req) begin
            // Hand over directly; the old owner is searched last.
            win   = rr_pick(req, sel_q + 2'd1);
            gnt_d = 4'b0001 << win;
            sel_d = win;
          end else begin
            state_d = IDLE;
            gnt_d   = 4'b0000;
            busy_d  = 1'b0;
          end
        end else if (xfer) begin
          if (cnt_q != '1) cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= 4'b0000;
      sel_q   <= 2'd0;
      last_q  <= 2'd3;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt  = gnt_q;
  assign sel  = sel_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_mux_4to1_rr_arbiter.sv
// Bench for mux_4to1_rr_arbiter: directed scenarios plus random traffic
// compared against a grant-level reference model.
module tb_mux_4to1_rr_arbiter;

  localparam int MB = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic       out_ready;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       out_valid;
  logic       busy;
`ifdef MUX_ARB_LOCK_EN
  logic       lock;
`endif

  int checks   = 0;
  int failures = 0;

  int m_owner, m_last, m_sel, m_beats;
  bit lk;
  bit obs_ov, exp_ov;

  mux_4to1_rr_arbiter #(.MAX_BURST(MB), .CNT_W(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .out_ready (out_ready),
`ifdef MUX_ARB_LOCK_EN
    .lock      (lock),
`endif
    .gnt       (gnt),
    .sel       (sel),
    .out_valid (out_valid),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  function automatic int pick(input logic [3:0] r, input int from_last);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = (from_last + k) % 4;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  function automatic logic [3:0] exp_gnt();
    if (m_owner < 0) return 4'b0000;
    return 4'(1 << m_owner);
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_last  = 3;
    m_sel   = 0;
    m_beats = 0;
  endtask

  task automatic model_step(input logic [3:0] r, input bit rdy);
    int o;
    bit xf, rl;
    if (m_owner < 0) begin
      if (r != 4'b0) begin
        m_owner = pick(r, m_last);
        m_sel   = m_owner;
        m_beats = 0;
      end
    end else begin
      o  = m_owner;
      xf = r[o] && rdy;
      rl = !r[o] || (xf && m_beats >= MB - 1 && !lk);
      if (rl) begin
        m_last  = o;
        m_beats = 0;
        if (r != 4'b0) begin
          m_owner = pick(r, o);
          m_sel   = m_owner;
        end else begin
          m_owner = -1;
        end
      end else if (xf) begin
        m_beats = (m_beats < 255) ? m_beats + 1 : 255;
      end
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req       = 4'b0;
    out_ready = 1'b0;
    lk        = 1'b0;
`ifdef MUX_ARB_LOCK_EN
    lock      = 1'b0;
`endif
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  // Applies inputs for one cycle; captures out_valid before the edge.
  task automatic drive_step(input logic [3:0] r, input bit rdy);
    int o;
    req       = r;
    out_ready = rdy;
    #1;
    obs_ov = out_valid;
    o      = m_owner;
    exp_ov = (o >= 0) ? r[o[1:0]] : 1'b0;
    @(posedge clk);
    model_step(r, rdy);
    #1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (gnt !== 4'b0 || sel !== 2'd0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: gnt=%b sel=%b busy=%b ov=%b want 0000 00 0 0",
               gnt, sel, busy, out_valid);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive_step(4'b0100, 1'b1);
    drive_step(4'b0100, 1'b1);
    checks++;
    if (gnt !== 4'b0100 || sel !== 2'd2 || busy !== 1'b1) begin
      failures++;
      $display("FAIL async_setup: gnt=%b sel=%b busy=%b want 0100 10 1",
               gnt, sel, busy);
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0 || sel !== 2'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: gnt=%b sel=%b busy=%b want 0000 00 0",
               gnt, sel, busy);
    end
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_all_req();
    int idx;
    do_reset();
    drive_step(4'b1111, 1'b1);
    checks++;
    if (gnt !== 4'b0001 || busy !== 1'b1) begin
      failures++;
      $display("FAIL all_first: gnt=%b busy=%b want 0001 1", gnt, busy);
    end
    for (int i = 0; i < 20; i++) begin
      drive_step(4'b1111, 1'b1);
      idx = ((i + 1) / 4) % 4;
      checks++;
      if (gnt !== 4'(1 << idx) || sel !== 2'(idx) || busy !== 1'b1 || obs_ov !== 1'b1) begin
        failures++;
        $display("FAIL all_rot[%0d]: gnt=%b sel=%b busy=%b ov=%b want %b %0d 1 1",
                 i, gnt, sel, busy, obs_ov, 4'(1 << idx), idx);
      end
    end
  endtask

  task automatic test_sole_req();
    do_reset();
    drive_step(4'b0010, 1'b1);
    for (int i = 0; i < 12; i++) begin
      drive_step(4'b0010, 1'b1);
      checks++;
      if (gnt !== 4'b0010 || sel !== 2'b01 || busy !== 1'b1 || obs_ov !== 1'b1) begin
        failures++;
        $display("FAIL sole[%0d]: gnt=%b sel=%b busy=%b ov=%b want 0010 01 1 1",
                 i, gnt, sel, busy, obs_ov);
      end
    end
  endtask

  task automatic test_drop();
    do_reset();
    drive_step(4'b1001, 1'b1);
    drive_step(4'b1001, 1'b1);
    drive_step(4'b1001, 1'b1);
    checks++;
    if (gnt !== 4'b0001) begin
      failures++;
      $display("FAIL drop_own: gnt=%b want 0001", gnt);
    end
    drive_step(4'b1000, 1'b1);
    checks++;
    if (obs_ov !== 1'b0 || gnt !== 4'b1000 || sel !== 2'b11 || busy !== 1'b1) begin
      failures++;
      $display("FAIL drop_handover: ov=%b gnt=%b sel=%b busy=%b want 0 1000 11 1",
               obs_ov, gnt, sel, busy);
    end
    for (int i = 0; i < 4; i++) begin
      drive_step(4'b1001, 1'b1);
      checks++;
      if (gnt !== ((i < 3) ? 4'b1000 : 4'b0001)) begin
        failures++;
        $display("FAIL drop_burst[%0d]: gnt=%b want %b",
                 i, gnt, (i < 3) ? 4'b1000 : 4'b0001);
      end
    end
    drive_step(4'b0000, 1'b1);
    checks++;
    if (gnt !== 4'b0 || busy !== 1'b0 || sel !== 2'b00) begin
      failures++;
      $display("FAIL drop_idle: gnt=%b busy=%b sel=%b want 0000 0 00", gnt, busy, sel);
    end
  endtask

  task automatic test_stall();
    do_reset();
    drive_step(4'b0011, 1'b0);
    for (int i = 0; i < 10; i++) begin
      drive_step(4'b0011, 1'b0);
      checks++;
      if (gnt !== 4'b0001 || sel !== 2'd0 || obs_ov !== 1'b1) begin
        failures++;
        $display("FAIL stall[%0d]: gnt=%b sel=%b ov=%b want 0001 00 1",
                 i, gnt, sel, obs_ov);
      end
    end
    for (int i = 0; i < 4; i++) begin
      drive_step(4'b0011, 1'b1);
      checks++;
      if (gnt !== ((i < 3) ? 4'b0001 : 4'b0010)) begin
        failures++;
        $display("FAIL stall_burst[%0d]: gnt=%b want %b",
                 i, gnt, (i < 3) ? 4'b0001 : 4'b0010);
      end
    end
  endtask

`ifdef MUX_ARB_LOCK_EN
  task automatic test_lock();
    do_reset();
    lock = 1'b1;
    lk   = 1'b1;
    drive_step(4'b0011, 1'b1);
    for (int b = 1; b <= 6; b++) begin
      drive_step(4'b0011, 1'b1);
      checks++;
      if (gnt !== 4'b0001) begin
        failures++;
        $display("FAIL lock_hold[%0d]: gnt=%b want 0001", b, gnt);
      end
    end
    lock = 1'b0;
    lk   = 1'b0;
    drive_step(4'b0011, 1'b1);
    checks++;
    if (gnt !== 4'b0010 || sel !== 2'b01) begin
      failures++;
      $display("FAIL lock_release: gnt=%b sel=%b want 0010 01", gnt, sel);
    end
  endtask
`endif

  task automatic test_random();
    logic [3:0] r;
    bit rdy;
    do_reset();
    r = 4'b0;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      drive_step(r, rdy);
      checks++;
      if (obs_ov !== exp_ov || gnt !== exp_gnt() || sel !== 2'(m_sel)
          || busy !== (m_owner >= 0)) begin
        failures++;
        $display("FAIL rand[%0d]: ov=%b gnt=%b sel=%b busy=%b want %b %b %0d %0d",
                 i, obs_ov, gnt, sel, busy, exp_ov, exp_gnt(), m_sel, m_owner >= 0);
      end
    end
  endtask

  initial begin
    test_reset();
    test_async_reset();
    test_all_req();
    test_sole_req();
    test_drop();
    test_stall();
`ifdef MUX_ARB_LOCK_EN
    test_lock();
`endif
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
